// File: rtl/data_mem_if_if.sv
// Data bus bundle between the MEM-stage load/store unit and memory.
// The LSU drives request fields; memory answers with gnt/rvalid/rdata.
interface data_mem_if_if;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  modport master (
    output dbus_req_o, dbus_we_o, dbus_addr_o,
    output dbus_be_o, dbus_wdata_o,
    input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
  );

  modport slave (
    input  dbus_req_o, dbus_we_o, dbus_addr_o,
    input  dbus_be_o, dbus_wdata_o,
    output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
  );
endinterface

// File: rtl/data_mem_if.sv
// MEM-stage load/store unit: runs one EX/MEM access over the data bus,
// stalls the pipe until it completes and returns extended load data.
module data_mem_if (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          stall_o,
  output logic [31:0]   rdata_o,
  output logic          misaligned_o,
  data_mem_if_if.master dbus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        w_access;
  logic        w_err;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;

  assign w_access = mem_read_i | mem_write_i;
  assign w_start  = (r_state == S_IDLE) & w_access;

  always_comb begin
    w_err = 1'b1;
    unique case (funct3_i)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = addr_i[0];
      3'b010:         w_err = |addr_i[1:0];
      default:        w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    unique case (1'b1)
      funct3_i[1:0] == 2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      funct3_i[1:0] == 2'b01: begin
        w_be    = 4'b0011 << addr_i[1:0];
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase
  end

  // Lane offset and size were captured at issue; the pipe may move on.
  assign w_shift = dbus.dbus_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    unique case (r_f3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ext = {24'b0, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ext = {16'b0, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_access) w_next = w_err ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (dbus.dbus_gnt_i) w_next = r_we ? S_DONE : S_WAIT_R;
      end
      S_WAIT_R: begin
        if (dbus.dbus_rvalid_i) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_f3    <= '0;
      r_off   <= '0;
    end else begin
      r_mis <= w_start & w_err;
      if (w_start && !w_err) begin
        r_req   <= 1'b1;
        r_we    <= ~mem_read_i;
        r_addr  <= {addr_i[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_f3    <= funct3_i;
        r_off   <= addr_i[1:0];
      end
      if (r_state == S_REQ && dbus.dbus_gnt_i)
        r_req <= 1'b0;
      if (r_state == S_WAIT_R && dbus.dbus_rvalid_i)
        r_rdata <= w_ext;
    end
  end

  assign stall_o = (r_state == S_REQ) |
                   (r_state == S_WAIT_R) |
                   w_start;

  assign rdata_o           = r_rdata;
  assign misaligned_o      = r_mis;
  assign dbus.dbus_req_o   = r_req;
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = r_addr;
  assign dbus.dbus_be_o    = r_be;
  assign dbus.dbus_wdata_o = r_wdata;

endmodule

// File: tb/tb_data_mem_if.sv
// Bench for data_mem_if: directed spec cases plus randomized
// back-to-back accesses checked against an arithmetic model.
module tb_data_mem_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  data_mem_if_if bus ();

  data_mem_if dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .dbus         (bus.master)
  );

  function automatic bit m_err(input logic [2:0] f3,
                               input logic [31:0] a);
    int o;
    o = int'(a % 4);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (o % 2) != 0;
      3'd2:       return o != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int v;
    if (m_size(f3) == 4) return 4'hF;
    v = ((1 << m_size(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] wd);
    if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin
        v = v & 32'hFF;
        if (v >= 128) v = v - 256;
      end
      3'd4: v = v & 32'hFF;
      3'd1: begin
        v = v & 32'hFFFF;
        if (v >= 32768) v = v - 65536;
      end
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // Drives one access from IDLE and acts as the memory; observes only.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  int          gd,
    input  int          rdl,
    input  logic [31:0] word,
    output int          stalls,
    output int          reqs,
    output int          mis_cnt,
    output logic [31:0] o_addr,
    output logic [3:0]  o_be,
    output logic        o_we,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output bit          unstable,
    output bit          late_req,
    output bit          tmo
  );
    int wc, gc;
    bit gdone, vdone, prev, done;
    stalls = 0; reqs = 0; mis_cnt = 0;
    o_addr = '0; o_be = '0; o_we = 1'b0;
    o_wdata = '0; o_rdata = '0;
    unstable = 0; late_req = 0; tmo = 0;
    wc = 0; gc = 0;
    gdone = 0; vdone = 0; prev = 0; done = 0;
    mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      bus.dbus_gnt_i = 1'b0;
      bus.dbus_rvalid_i = 1'b0;
      bus.dbus_rdata_i = $urandom;
      if (bus.dbus_req_o) begin
        if (!prev) begin
          reqs++;
          o_addr = bus.dbus_addr_o;
          o_be = bus.dbus_be_o;
          o_we = bus.dbus_we_o;
          o_wdata = bus.dbus_wdata_o;
        end else if (bus.dbus_addr_o !== o_addr ||
                     bus.dbus_be_o !== o_be ||
                     bus.dbus_we_o !== o_we ||
                     bus.dbus_wdata_o !== o_wdata) begin
          unstable = 1;
        end
        if (gdone) begin
          late_req = 1;
        end else if (wc == gd) begin
          bus.dbus_gnt_i = 1'b1;
          gdone = 1;
          gc = c;
        end
        wc++;
      end
      if (rd && gdone && !vdone && c > gc && c == gc + rdl) begin
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i = word;
        vdone = 1;
      end
      prev = bus.dbus_req_o;
      #1;
      if (stall_o) stalls++;
      if (misaligned_o) mis_cnt++;
      if (!stall_o) begin
        done = 1;
        o_rdata = rdata_o;
      end
      @(posedge clk); #1;
    end
    tmo = !done;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    bus.dbus_gnt_i = 1'b0;
    bus.dbus_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dbus_gnt_i = 1'b0;
    bus.dbus_rvalid_i = 1'b0;
    bus.dbus_rdata_i = '0;
    #2;
    checks++;
    if ({bus.dbus_req_o, bus.dbus_we_o, misaligned_o, stall_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {bus.dbus_req_o, bus.dbus_we_o, misaligned_o, stall_o});
    end
    checks++;
    if ({bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, rdata_o} !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h be=%b wd=%h rd=%h exp all 0",
               bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, rdata_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_rdata = '0;
  endtask

  task automatic test_lw();
    int st, rq, mc;
    logic [31:0] ad, wd, rv;
    logic [3:0] be;
    logic we;
    bit un, lr, to;
    run_access(1, 0, 3'd2, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF,
               st, rq, mc, ad, be, we, wd, rv, un, lr, to);
    exp_rdata = 32'hDEADBEEF;
    checks++;
    if (to || ad !== 32'h100 || be !== 4'hF || we !== 1'b0) begin
      failures++;
      $display("FAIL lw_bus to=%0d addr=%h be=%b we=%b exp 100/1111/0",
               to, ad, be, we);
    end
    checks++;
    if (st !== 4) begin
      failures++;
      $display("FAIL lw_stalls got=%0d exp=4", st);
    end
    checks++;
    if (rv !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_rdata got=%h exp=deadbeef", rv);
    end
  endtask

  task automatic test_lb_lbu();
    int st, rq, mc;
    logic [31:0] ad, wd, rv;
    logic [3:0] be;
    logic we;
    bit un, lr, to;
    run_access(1, 0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80123456,
               st, rq, mc, ad, be, we, wd, rv, un, lr, to);
    checks++;
    if (rv !== 32'hFFFFFF80 || be !== 4'b1000) begin
      failures++;
      $display("FAIL lb rdata=%h be=%b exp ffffff80/1000", rv, be);
    end
    run_access(1, 0, 3'd4, 32'h103, 32'h0, 0, 2, 32'h80123456,
               st, rq, mc, ad, be, we, wd, rv, un, lr, to);
    exp_rdata = 32'h00000080;
    checks++;
    if (rv !== 32'h00000080 || st !== 4) begin
      failures++;
      $display("FAIL lbu rdata=%h stalls=%0d exp 00000080/4", rv, st);
    end
  endtask

  task automatic test_lhu();
    int st, rq, mc;
    logic [31:0] ad, wd, rv;
    logic [3:0] be;
    logic we;
    bit un, lr, to;
    run_access(1, 0, 3'd5, 32'h202, 32'h0, 0, 1, 32'hBEEF1234,
               st, rq, mc, ad, be, we, wd, rv, un, lr, to);
    exp_rdata = 32'h0000BEEF;
    checks++;
    if (be !== 4'b1100 || ad !== 32'h200) begin
      failures++;
      $display("FAIL lhu_bus be=%b addr=%h exp 1100/200", be, ad);
    end
    checks++;
    if (rv !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL lhu_rdata got=%h exp=0000beef", rv);
    end
  endtask

  task automatic test_sb();
    int st, rq, mc;
    logic [31:0] ad, wd, rv;
    logic [3:0] be;
    logic we;
    bit un, lr, to;
    run_access(0, 1, 3'd0, 32'h101, 32'h000000AB, 0, 1, 32'h0,
               st, rq, mc, ad, be, we, wd, rv, un, lr, to);
    checks++;
    if (we !== 1'b1 || be !== 4'b0010 || wd !== 32'hABABABAB) begin
      failures++;
      $display("FAIL sb_bus we=%b be=%b wd=%h exp 1/0010/abababab",
               we, be, wd);
    end
    checks++;
    if (st !== 2 || rq !== 1) begin
      failures++;
      $display("FAIL sb_stalls stalls=%0d reqs=%0d exp 2/1", st, rq);
    end
    checks++;
    if (rv !== exp_rdata) begin
      failures++;
      $display("FAIL sb_rdata got=%h exp=%h", rv, exp_rdata);
    end
  endtask

  task automatic test_errors();
    int st, rq, mc;
    logic [31:0] ad, wd, rv;
    logic [3:0] be;
    logic we;
    bit un, lr, to;
    logic [2:0] f3s [2];
    logic [31:0] as [2];
    f3s[0] = 3'd2; as[0] = 32'h106;
    f3s[1] = 3'd3; as[1] = 32'h100;
    for (int k = 0; k < 2; k++) begin
      run_access(1, 0, f3s[k], as[k], 32'h0, 0, 1, 32'h12345678,
                 st, rq, mc, ad, be, we, wd, rv, un, lr, to);
      checks++;
      if (rq !== 0 || st !== 1 || mc !== 1) begin
        failures++;
        $display("FAIL err%0d reqs=%0d stalls=%0d mis=%0d exp 0/1/1",
                 k, rq, st, mc);
      end
      checks++;
      if (rv !== exp_rdata) begin
        failures++;
        $display("FAIL err%0d_rdata got=%h exp=%h", k, rv, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int st, rq, mc, gd, rdl, es;
    logic [31:0] ad, wd, rv, a, w, word;
    logic [3:0] be;
    logic we, rd, wr;
    logic [2:0] f3;
    bit un, lr, to, err;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom % 2);
      wr = rd ? 1'($urandom % 2) : 1'b1;
      f3 = 3'($urandom % 8);
      a = $urandom;
      w = $urandom;
      word = $urandom;
      gd = $urandom_range(0, 3);
      rdl = $urandom_range(1, 3);
      err = m_err(f3, a);
      run_access(rd, wr, f3, a, w, gd, rdl, word,
                 st, rq, mc, ad, be, we, wd, rv, un, lr, to);
      if (!err && rd) exp_rdata = m_load(f3, a, word);
      es = err ? 1 : (rd ? 2 + gd + rdl : 2 + gd);
      checks++;
      if (to || st !== es) begin
        failures++;
        $display("FAIL rnd%0d_stalls to=%0d got=%0d exp=%0d",
                 i, to, st, es);
      end
      checks++;
      if (rq !== (err ? 0 : 1) || mc !== (err ? 1 : 0) || un || lr) begin
        failures++;
        $display("FAIL rnd%0d_proto reqs=%0d mis=%0d unst=%0d late=%0d",
                 i, rq, mc, un, lr);
      end
      checks++;
      if (rv !== exp_rdata) begin
        failures++;
        $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rv, exp_rdata);
      end
      if (!err) begin
        checks++;
        if (ad !== {a[31:2], 2'b00} || be !== m_be(f3, a) ||
            we !== !rd) begin
          failures++;
          $display("FAIL rnd%0d_bus addr=%h be=%b we=%b exp %h/%b/%b",
                   i, ad, be, we, {a[31:2], 2'b00}, m_be(f3, a), !rd);
        end
        if (!rd) begin
          checks++;
          if (wd !== m_wdata(f3, w)) begin
            failures++;
            $display("FAIL rnd%0d_wdata got=%h exp=%h",
                     i, wd, m_wdata(f3, w));
          end
        end
      end
    end
  endtask

  task automatic test_reset_wait_r();
    mem_read_i = 1'b1;
    funct3_i = 3'd2;
    addr_i = 32'h300;
    @(posedge clk); #1;
    bus.dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.dbus_gnt_i = 1'b0;
    mem_read_i = 1'b0;
    checks++;
    if (stall_o !== 1'b1 || bus.dbus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_pre stall=%b req=%b exp 1/0",
               stall_o, bus.dbus_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dbus_req_o, bus.dbus_we_o, misaligned_o, stall_o} !== 4'b0 ||
        {bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, rdata_o} !== '0) begin
      failures++;
      $display("FAIL rst_wr_async req=%b addr=%h be=%b rd=%h stall=%b",
               bus.dbus_req_o, bus.dbus_addr_o, bus.dbus_be_o,
               rdata_o, stall_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dbus_rvalid_i = 1'b1;
    bus.dbus_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.dbus_rvalid_i = 1'b0;
    checks++;
    if (rdata_o !== 32'h0 || bus.dbus_req_o !== 1'b0 ||
        stall_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_late_rvalid rd=%h req=%b stall=%b exp 0/0/0",
               rdata_o, bus.dbus_req_o, stall_o);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_lhu();
    test_sb();
    test_errors();
    test_back_to_back_random();
    test_reset_wait_r();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
